truth_table_scanner: RTL and testbench

Sequential stimulus/capture stage placed around the team's combinational 4-input logic-function blocks (mux/decoder style, inputs a..d, output F). On a start request it drives every input combination 0..2^N_IN-1 into the function block. It waits a settle interval for each vector and captures the function's output into a truth-table register. The result is a packed truth table plus a ones count for downstream display or checking.

---
 rtl/scanner_pkg.sv | 20 ++
 rtl/scan_settle_timer.sv | 32 +++
 rtl/truth_table_scanner.sv | 120 ++++++++++++
 tb/tb_truth_table_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared types and width helpers for the truth-table scanner.
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Truth-table width for a function with n_in inputs.
  function automatic int unsigned tbl_w(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Settle counter width; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned settle);
    return (settle < 32'd2) ? 32'd1 : $clog2(settle + 32'd1);
  endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Per-vector settle timer: counts 0..SETTLE while enabled, ticks on terminal count.
module scan_settle_timer
  import scanner_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = cnt_w(SETTLE);
  localparam logic [CW-1:0] TERM = CW'(SETTLE);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == TERM) count <= '0;
      else               count <= count + CW'(1);
    end
  end

  assign tick_c = en && (count == TERM);

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input combination into a combinational function and captures its truth table.
// Optional SCAN_COMPARE_EN adds a compare of the captured table against an expected table.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned TW    = tbl_w(N_IN),
  localparam int unsigned OW    = N_IN + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            fn_out,
`ifdef SCAN_COMPARE_EN
  input  logic [TW-1:0]   expected,
  output logic            match,
  output logic [N_IN-1:0] first_bad,
`endif
  output logic [N_IN-1:0] fn_in,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   truth_table,
  output logic [OW-1:0]   ones_count
);

  scan_state_t state;
  logic        accept_c;
  logic        run_c;
  logic        tick_c;
  logic        last_c;

  assign accept_c = (state == IDLE) && start;
  assign run_c    = (state == RUN);
  assign last_c   = (fn_in == N_IN'(TW - 1));

  scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_c),
    .en     (run_c),
    .tick_c (tick_c)
  );

`ifdef SCAN_COMPARE_EN
  logic [TW-1:0]   exp_q;
  logic [TW-1:0]   final_c;
  logic [TW-1:0]   diff_c;
  logic [N_IN-1:0] bad_c;

  // Table as it will look after the current capture, so the verdict lands with done.
  always_comb begin
    final_c        = truth_table;
    final_c[fn_in] = fn_out;
    diff_c         = final_c ^ exp_q;
    bad_c          = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      if (diff_c[i]) bad_c = N_IN'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fn_in       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
`ifdef SCAN_COMPARE_EN
      exp_q       <= '0;
      match       <= 1'b0;
      first_bad   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            truth_table <= '0;
            ones_count  <= '0;
            fn_in       <= '0;
            busy        <= 1'b1;
            state       <= RUN;
`ifdef SCAN_COMPARE_EN
            exp_q       <= expected;
            match       <= 1'b0;
            first_bad   <= '0;
`endif
          end
        end
        RUN: begin
          if (tick_c) begin
            truth_table[fn_in] <= fn_out;
            ones_count         <= ones_count + OW'(fn_out);
            if (last_c) begin
              fn_in <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`ifdef SCAN_COMPARE_EN
              match     <= (diff_c == '0);
              first_bad <= bad_c;
`endif
            end else begin
              fn_in <= fn_in + N_IN'(1);
            end
          end
        end
        DONE: begin
          fn_in <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: two scanners (SETTLE=1 and SETTLE=0) driven by a selectable model function.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [1:0]  mode;
  logic [3:0]  fn_in0, fn_in1;
  logic        fn_out0, fn_out1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] tbl0, tbl1;
  logic [4:0]  ones0, ones1;
`ifdef SCAN_COMPARE_EN
  logic [15:0] expected0, expected1;
  logic        match0, match1;
  logic [3:0]  first_bad0, first_bad1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Function under scan: 0 const0, 1 const1, 2 true on 0000/0101/1010/1111, 3 F = d.
  function automatic logic fn_model(input logic [3:0] x, input logic [1:0] m);
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return x[3:2] == x[1:0];
      default: return x[0];
    endcase
  endfunction

  assign fn_out0 = fn_model(fn_in0, mode);
  assign fn_out1 = fn_model(fn_in1, mode);

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .fn_out(fn_out0),
`ifdef SCAN_COMPARE_EN
    .expected(expected0), .match(match0), .first_bad(first_bad0),
`endif
    .fn_in(fn_in0), .busy(busy0), .done(done0),
    .truth_table(tbl0), .ones_count(ones0)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .fn_out(fn_out1),
`ifdef SCAN_COMPARE_EN
    .expected(expected1), .match(match1), .first_bad(first_bad1),
`endif
    .fn_in(fn_in1), .busy(busy1), .done(done1),
    .truth_table(tbl1), .ones_count(ones1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction
  function automatic logic [3:0] fn_in_of(input int sel);
    return (sel == 0) ? fn_in0 : fn_in1;
  endfunction

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (sel == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  // Entered on the first busy negedge; returns on the negedge after the DONE cycle.
  task automatic watch_scan(input int sel, input int settle, input logic [15:0] exp_tbl,
                            input logic [4:0] exp_ones, input int exp_busy);
    int n = 0;
    bit seq_ok = 1'b1;
    bit early_done = 1'b0;
    while (busy_of(sel) && n < 1000) begin
      if (fn_in_of(sel) !== 4'(n / (settle + 1))) seq_ok = 1'b0;
      if (done_of(sel)) early_done = 1'b1;
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'(exp_busy));
    check("fn_in_seq", 32'(seq_ok), 32'd1);
    check("done_early", 32'(early_done), 32'd0);
    check("done_pulse", 32'(done_of(sel)), 32'd1);
    check("table", 32'((sel == 0) ? tbl0 : tbl1), 32'(exp_tbl));
    check("ones", 32'((sel == 0) ? ones0 : ones1), 32'(exp_ones));
    check("fn_in_done", 32'(fn_in_of(sel)), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done_of(sel)), 32'd0);
  endtask

  initial begin
    bit bad;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mode   = 2'd2;
`ifdef SCAN_COMPARE_EN
    expected0 = 16'h8421;
    expected1 = 16'h0000;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_table", 32'(tbl0), 32'd0);
    check("rst_ones", 32'(ones0), 32'd0);
    check("rst_fn_in", 32'(fn_in0), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy0 || done0 || fn_in0 != 4'd0 || tbl0 != 16'd0) bad = 1'b1;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Match function, SETTLE=1
    mode = 2'd2;
    pulse_start(0);
    watch_scan(0, 1, 16'h8421, 5'd4, 32);
`ifdef SCAN_COMPARE_EN
    check("match_eq", 32'(match0), 32'd1);
    check("first_bad_eq", 32'(first_bad0), 32'd0);
`endif
    repeat (5) @(negedge clk);
    check("table_held", 32'(tbl0), 32'h8421);
    check("ones_held", 32'(ones0), 32'd4);

`ifdef SCAN_COMPARE_EN
    expected0 = 16'h8423;
    pulse_start(0);
    watch_scan(0, 1, 16'h8421, 5'd4, 32);
    check("match_ne", 32'(match0), 32'd0);
    check("first_bad_ne", 32'(first_bad0), 32'd1);
`endif

    // Constant functions
    mode = 2'd0;
    pulse_start(0);
    watch_scan(0, 1, 16'h0000, 5'd0, 32);
    mode = 2'd1;
    pulse_start(0);
    watch_scan(0, 1, 16'hFFFF, 5'd16, 32);

    // SETTLE=0, F = d, start held high for two back-to-back scans
    mode = 2'd3;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    watch_scan(1, 0, 16'hAAAA, 5'd8, 16);
    check("gap_idle", 32'(busy1), 32'd0);
    @(negedge clk);
    check("restart", 32'(busy1), 32'd1);
    watch_scan(1, 0, 16'hAAAA, 5'd8, 16);
    start1 = 1'b0;
    @(negedge clk);
    check("no_third", 32'(busy1), 32'd0);

    // Abort mid-scan with asynchronous reset
    mode = 2'd2;
    pulse_start(0);
    repeat (10) @(negedge clk);
    check("abort_pre_busy", 32'(busy0), 32'd1);
    check("abort_pre_table", 32'(tbl0 != 16'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_table", 32'(tbl0), 32'd0);
    check("abort_ones", 32'(ones0), 32'd0);
    check("abort_fn_in", 32'(fn_in0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) bad = 1'b1;
    end
    check("abort_quiet", 32'(bad), 32'd0);
`ifdef SCAN_COMPARE_EN
    expected0 = 16'h8421;
`endif
    pulse_start(0);
    watch_scan(0, 1, 16'h8421, 5'd4, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
